sum_ascii_framer: RTL and testbench

SUM_ASCII_FRAMER -- requirements
Module: sum_ascii_framer

---
 rtl/sum_ascii_framer.sv | 155 +++++++++++++++
 tb/tb_sum_ascii_framer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_ascii_framer.sv
// Reports a 5-bit sum over a UART byte interface as two ASCII decimal digits,
// optionally followed by CR/LF, with a bounded wait for the transmitter's busy acknowledge.
module sum_ascii_framer #(
    parameter int unsigned EOL_EN      = 1,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] sum,
    input  logic       send,
    input  logic       uart_tx_busy,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    output logic       busy,
    output logic       done
);

    localparam int unsigned NUM_BYTES = (EOL_EN != 0) ? 4 : 2;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned TMR_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       value_q, value_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             en_d;
    logic [7:0]       data_d;
    logic             busy_d;
    logic             done_d;

    logic [1:0]       tens;
    logic [3:0]       ones;
    logic [7:0]       cur_byte;

    // Binary to two decimal digits; the value never exceeds 31, so tens is 0..3.
    always_comb begin
        tens = 2'd0;
        ones = 4'(value_q);
        if (value_q >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(value_q - 5'd30);
        end else if (value_q >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(value_q - 5'd20);
        end else if (value_q >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(value_q - 5'd10);
        end
    end

    // Byte selected by the frame position.
    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = {6'b001100, tens};
            2'd1:    cur_byte = {4'h3, ones};
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        en_d    = 1'b0;
        data_d  = uart_tx_data;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (send) begin
                    value_d = sum;
                    idx_d   = '0;
                    tmr_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_d = '0;
                if (!uart_tx_busy) begin
                    en_d    = 1'b1;
                    data_d  = cur_byte;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // A transmitter that never acknowledges must not stall the frame.
                if (uart_tx_busy || (tmr_q == TMR_LAST)) begin
                    tmr_d   = '0;
                    state_d = S_WAIT_DONE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            value_q      <= '0;
            idx_q        <= '0;
            tmr_q        <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            idx_q        <= idx_d;
            tmr_q        <= tmr_d;
            uart_tx_en   <= en_d;
            uart_tx_data <= data_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_sum_ascii_framer.sv
// Drives two framers (with and without CR/LF) from shared stimulus, each against its own
// UART model, and compares the issued bytes with frames computed from the decimal rules.
module tb_sum_ascii_framer;

    localparam int unsigned ACK_TO = 15;
    localparam int BUDGET = 3000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       send;
    logic [4:0] sum;
    logic       hold_busy;
    int         busy_len;

    logic       ub0, ub1;
    int         cnt0, cnt1;
    logic       en0, en1;
    logic [7:0] d0, d1;
    logic       bz0, bz1, dn0, dn1;

    int errors = 0;
    int checks = 0;

    logic [7:0] got0[$];
    logic [7:0] got1[$];
    int         t0[$];
    int         cyc = 0;
    int         done0 = 0, done1 = 0, dbl_en = 0, unstable = 0;
    logic       pen0 = 1'b0, pen1 = 1'b0;
    logic [7:0] pd0 = 8'h00, pd1 = 8'h00;

    always #5 clk = ~clk;

    sum_ascii_framer #(.EOL_EN(1), .ACK_TIMEOUT(ACK_TO)) dut0 (
        .clk(clk), .reset_n(reset_n), .sum(sum), .send(send), .uart_tx_busy(ub0),
        .uart_tx_en(en0), .uart_tx_data(d0), .busy(bz0), .done(dn0)
    );

    sum_ascii_framer #(.EOL_EN(0), .ACK_TIMEOUT(ACK_TO)) dut1 (
        .clk(clk), .reset_n(reset_n), .sum(sum), .send(send), .uart_tx_busy(ub1),
        .uart_tx_en(en1), .uart_tx_data(d1), .busy(bz1), .done(dn1)
    );

    // UART models: busy for busy_len cycles after each accepted byte (never, if 0).
    assign ub0 = hold_busy | (cnt0 > 0);
    assign ub1 = hold_busy | (cnt1 > 0);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0 <= 0;
            cnt1 <= 0;
        end else begin
            if (en0 && busy_len > 0) cnt0 <= busy_len;
            else if (cnt0 > 0)       cnt0 <= cnt0 - 1;
            if (en1 && busy_len > 0) cnt1 <= busy_len;
            else if (cnt1 > 0)       cnt1 <= cnt1 - 1;
        end
    end

    // Byte capture and protocol observation, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (en0) begin
            got0.push_back(d0);
            t0.push_back(cyc);
        end
        if (en1) got1.push_back(d1);
        if (dn0) done0 <= done0 + 1;
        if (dn1) done1 <= done1 + 1;
        if ((en0 && pen0) || (en1 && pen1)) dbl_en <= dbl_en + 1;
        if (reset_n && ((!en0 && d0 !== pd0) || (!en1 && d1 !== pd1))) unstable <= unstable + 1;
        pen0 <= en0;
        pen1 <= en1;
        pd0  <= d0;
        pd1  <= d1;
    end

    function automatic logic [7:0] exp_byte(input int v, input int k);
        case (k)
            0:       return 8'(48 + v / 10);
            1:       return 8'(48 + v % 10);
            2:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_capture();
        got0.delete();
        got1.delete();
        t0.delete();
    endtask

    // Waits until both instances report a new done beyond the given baselines.
    task automatic wait_both_done(input int b0, input int b1, input string name);
        int bud;
        bud = 0;
        while ((done0 == b0 || done1 == b1) && bud < BUDGET) begin
            step();
            bud++;
        end
        checks++;
        if (bud >= BUDGET) begin
            errors++;
            $display("FAIL %s done_timeout: done0=%0d done1=%0d required >%0d/>%0d",
                     name, done0, done1, b0, b1);
        end
    endtask

    task automatic check_frames(input int v, input string name);
        checks++;
        if (got0.size() != 4) begin
            errors++;
            $display("FAIL %s eol_len: got %0d bytes required 4", name, got0.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got0[k] !== exp_byte(v, k)) begin
                    errors++;
                    $display("FAIL %s eol_byte%0d: got %h required %h", name, k, got0[k], exp_byte(v, k));
                end
            end
        end
        checks++;
        if (got1.size() != 2) begin
            errors++;
            $display("FAIL %s noeol_len: got %0d bytes required 2", name, got1.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got1[k] !== exp_byte(v, k)) begin
                    errors++;
                    $display("FAIL %s noeol_byte%0d: got %h required %h", name, k, got1[k], exp_byte(v, k));
                end
            end
        end
    endtask

    // One complete frame; caller guarantees both instances are idle.
    task automatic do_frame(input int v, input string name);
        int b0, b1;
        b0 = done0;
        b1 = done1;
        clear_capture();
        sum  = 5'(v);
        send = 1'b1;
        step();
        send = 1'b0;
        checks++;
        if (bz0 !== 1'b1 || bz1 !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_rise: got %b%b required 11", name, bz0, bz1);
        end
        wait_both_done(b0, b1, name);
        repeat (3) step();
        checks++;
        if (done0 != b0 + 1 || done1 != b1 + 1 || bz0 !== 1'b0 || bz1 !== 1'b0) begin
            errors++;
            $display("FAIL %s done_once: got done=%0d/%0d busy=%b%b required %0d/%0d busy=00",
                     name, done0 - b0, done1 - b1, bz0, bz1, 1, 1);
        end
        check_frames(v, name);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        send      = 1'b0;
        sum       = 5'd0;
        hold_busy = 1'b0;
        busy_len  = 10;
        repeat (3) step();
        checks++;
        if ({en0, d0, bz0, dn0} !== 11'd0 || {en1, d1, bz1, dn1} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b %b required all zero", {en0, d0, bz0, dn0}, {en1, d1, bz1, dn1});
        end
        reset_n = 1'b1;
        repeat (5) step();
        checks++;
        if ({en0, d0, bz0, dn0} !== 11'd0 || {en1, d1, bz1, dn1} !== 11'd0 || got0.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: got %b %b bytes=%0d required all zero", {en0, d0, bz0, dn0},
                     {en1, d1, bz1, dn1}, got0.size());
        end
    endtask

    task automatic test_basic();
        busy_len = 10;
        do_frame(23, "basic23");
    endtask

    task automatic test_digits();
        busy_len = 4;
        do_frame(7, "digits7");
        do_frame(0, "digits0");
        do_frame(31, "digits31");
        do_frame(30, "digits30");
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 6; i++) begin
            busy_len = int'($urandom_range(1, 12));
            v = int'($urandom_range(0, 31));
            do_frame(v, "random");
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic test_capture();
        int b0, b1;
        busy_len = 10;
        b0 = done0;
        b1 = done1;
        clear_capture();
        sum  = 5'd12;
        send = 1'b1;
        step();
        send = 1'b0;
        sum  = 5'd5;
        repeat (3) step();
        send = 1'b1;
        step();
        send = 1'b0;
        wait_both_done(b0, b1, "capture");
        repeat (60) step();
        checks++;
        if (done0 != b0 + 1 || done1 != b1 + 1) begin
            errors++;
            $display("FAIL capture_no_requeue: got done=%0d/%0d required 1/1", done0 - b0, done1 - b1);
        end
        check_frames(12, "capture");
    endtask

    task automatic test_busy_hold();
        int b0, b1;
        busy_len  = 6;
        hold_busy = 1'b1;
        b0 = done0;
        b1 = done1;
        clear_capture();
        sum  = 5'd18;
        send = 1'b1;
        step();
        send = 1'b0;
        repeat (20) step();
        checks++;
        if (got0.size() != 0 || got1.size() != 0 || bz0 !== 1'b1 || bz1 !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold: got bytes=%0d/%0d busy=%b%b required 0/0 busy=11",
                     got0.size(), got1.size(), bz0, bz1);
        end
        hold_busy = 1'b0;
        wait_both_done(b0, b1, "busy_hold");
        check_frames(18, "busy_hold");
    endtask

    task automatic test_timeout();
        int gap;
        busy_len = 0;
        do_frame(9, "timeout");
        for (int k = 1; k < t0.size(); k++) begin
            gap = t0[k] - t0[k-1];
            checks++;
            if (gap < int'(ACK_TO) || gap > int'(ACK_TO) + 4) begin
                errors++;
                $display("FAIL timeout_gap%0d: got %0d cycles required %0d..%0d", k, gap, ACK_TO, ACK_TO + 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b0, b1, bud;
        busy_len = 10;
        b0 = done0;
        b1 = done1;
        clear_capture();
        sum  = 5'd27;
        send = 1'b1;
        step();
        send = 1'b0;
        bud = 0;
        while (got0.size() < 2 && bud < BUDGET) begin
            step();
            bud++;
        end
        checks++;
        if (bud >= BUDGET) begin
            errors++;
            $display("FAIL reset_mid_second_byte: got %0d bytes required 2", got0.size());
        end
        step();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({en0, d0, bz0, dn0} !== 11'd0 || {en1, d1, bz1, dn1} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b %b required all zero", {en0, d0, bz0, dn0}, {en1, d1, bz1, dn1});
        end
        repeat (3) step();
        reset_n = 1'b1;
        clear_capture();
        repeat (10) step();
        checks++;
        if (done0 != b0 || done1 != b1 || got0.size() != 0 || got1.size() != 0 || bz0 !== 1'b0 || bz1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: got done=%0d/%0d bytes=%0d/%0d busy=%b%b required 0/0 0/0 busy=00",
                     done0 - b0, done1 - b1, got0.size(), got1.size(), bz0, bz1);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        do_frame(19, "after_reset19");
    endtask

    task automatic test_protocol();
        checks++;
        if (dbl_en != 0) begin
            errors++;
            $display("FAIL en_back_to_back: got %0d occurrences required 0", dbl_en);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL data_stable: got %0d changes outside issue required 0", unstable);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_digits();
        test_random();
        test_capture();
        test_busy_hold();
        test_timeout();
        test_reset_mid();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
